// File: rtl/program_loader.sv
// Streaming image loader: parses header/payload words and writes the IM and DM
// of Pipe_CPU_1 with single-cycle strobes, holding the CPU in reset until END.
module program_loader #(
  parameter int IM_WORDS = 256,
  parameter int DM_WORDS = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_data_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_data_o,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {HDR, DATA, DONE, ERR} state_t;

  state_t      state;
  logic        tgt_dm;
  logic [11:0] idx;
  logic [11:0] remain;

  logic        xfer;
  logic [1:0]  hdr_tgt;
  logic [11:0] hdr_base;
  logic [11:0] hdr_cnt;
  logic [12:0] hdr_end;
  logic        hdr_oob;

  assign xfer     = in_valid_i & in_ready_o;
  assign hdr_tgt  = in_data_i[31:30];
  assign hdr_base = in_data_i[23:12];
  assign hdr_cnt  = in_data_i[11:0];

  // 13-bit sum so base+N cannot wrap past the memory depth
  always_comb begin
    hdr_end = {1'b0, hdr_base} + {1'b0, hdr_cnt};
    hdr_oob = hdr_tgt[0] ? (hdr_end > 13'(DM_WORDS)) : (hdr_end > 13'(IM_WORDS));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= HDR;
      tgt_dm     <= 1'b0;
      idx        <= '0;
      remain     <= '0;
      in_ready_o <= 1'b0;
      im_we_o    <= 1'b0;
      im_addr_o  <= '0;
      im_data_o  <= '0;
      dm_we_o    <= 1'b0;
      dm_addr_o  <= '0;
      dm_data_o  <= '0;
      cpu_rst_o  <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      im_we_o <= 1'b0;
      dm_we_o <= 1'b0;
      case (state)
        HDR: begin
          in_ready_o <= 1'b1;
          if (xfer) begin
            case (hdr_tgt)
              2'b00, 2'b01: begin
                if (hdr_oob) begin
                  state      <= ERR;
                  in_ready_o <= 1'b0;
                  err_o      <= 1'b1;
                end else if (hdr_cnt != 12'd0) begin
                  state  <= DATA;
                  tgt_dm <= hdr_tgt[0];
                  idx    <= hdr_base;
                  remain <= hdr_cnt;
                end
              end
              2'b11: begin
                state      <= DONE;
                in_ready_o <= 1'b0;
                done_o     <= 1'b1;
                cpu_rst_o  <= 1'b1;
              end
              default: begin
                state      <= ERR;
                in_ready_o <= 1'b0;
                err_o      <= 1'b1;
              end
            endcase
          end
        end
        DATA: begin
          in_ready_o <= 1'b1;
          if (xfer) begin
            if (tgt_dm) begin
              dm_we_o   <= 1'b1;
              dm_addr_o <= {18'd0, idx, 2'b00};
              dm_data_o <= in_data_i;
            end else begin
              im_we_o   <= 1'b1;
              im_addr_o <= {18'd0, idx, 2'b00};
              im_data_o <= in_data_i;
            end
            idx    <= idx + 12'd1;
            remain <= remain - 12'd1;
            if (remain == 12'd1) state <= HDR;
          end
        end
        default: in_ready_o <= 1'b0;
      endcase
    end
  end

endmodule
